// File: rtl/fetch_unit_if.sv
// fetch_unit_if: groups the fetch stage's three buses into one bundle.
//   redirect_valid/redirect_target : PC redirect from the branch generator
//   imem_req/imem_addr             : word fetch request (fetch -> memory)
//   imem_gnt/imem_rvalid/imem_rdata: accept strobe and response (memory -> fetch)
//   if_valid/if_pc/if_inst         : instruction presented to decode
//   if_ready                       : decode accepts the presented instruction
// master = the fetch unit's view, slave = the surrounding environment's view.
interface fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  modport master (
    input  redirect_valid, redirect_target,
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output if_valid, if_pc, if_inst,
    input  if_ready
  );

  modport slave (
    output redirect_valid, redirect_target,
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  if_valid, if_pc, if_inst,
    output if_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the fetch PC, issues one word
// request at a time to instruction memory (req/gnt then rvalid), and presents
// {pc, inst} to decode with valid/ready. A redirect replaces the fetch PC and
// squashes whatever is in flight or held.
//   clk   : system clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fetch_unit_if.master (redirect, imem, decode handshake)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} state_t;

  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

  state_t      r_state,    w_state_nxt;
  logic [31:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [31:0] r_req_pc,   w_req_pc_nxt;
  logic        r_discard,  w_discard_nxt;
  logic        r_if_valid, w_if_valid_nxt;
  logic [31:0] r_if_pc,    w_if_pc_nxt;
  logic [31:0] r_if_inst,  w_if_inst_nxt;
  // Holds imem_req low for the first cycle out of reset.
  logic        r_live;

  logic        w_req;
  logic        w_gnt;
  logic        w_redir;
  logic [31:0] w_tgt;
  logic [1:0]  w_unused_tgt_lo;

  assign w_redir         = bus.redirect_valid;
  assign w_tgt           = {bus.redirect_target[31:2], 2'b00};
  assign w_unused_tgt_lo = bus.redirect_target[1:0];
  assign w_req           = r_live && (r_state == S_REQ);
  // gnt only means something while we are requesting.
  assign w_gnt           = w_req && bus.imem_gnt;

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_pc_nxt   = r_req_pc;
    w_discard_nxt  = r_discard;
    w_if_valid_nxt = r_if_valid;
    w_if_pc_nxt    = r_if_pc;
    w_if_inst_nxt  = r_if_inst;
    case (r_state)
      S_REQ: begin
        if (w_gnt) begin
          w_state_nxt  = S_WAIT;
          w_req_pc_nxt = r_fetch_pc;
          // Request already left with the old address: drop its response.
          if (w_redir) w_discard_nxt = 1'b1;
        end
        if (w_redir) w_fetch_pc_nxt = w_tgt;
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          if (r_discard || w_redir) begin
            w_discard_nxt = 1'b0;
            w_state_nxt   = S_REQ;
          end else begin
            w_if_valid_nxt = 1'b1;
            w_if_pc_nxt    = r_req_pc;
            w_if_inst_nxt  = bus.imem_rdata;
            w_fetch_pc_nxt = r_req_pc + 32'd4;
            w_state_nxt    = S_OUT;
          end
        end else if (w_redir) begin
          w_discard_nxt = 1'b1;
        end
        // Latest redirect target always wins.
        if (w_redir) w_fetch_pc_nxt = w_tgt;
      end
      S_OUT: begin
        if (w_redir) begin
          w_if_valid_nxt = 1'b0;
          w_fetch_pc_nxt = w_tgt;
          w_state_nxt    = S_REQ;
        end else if (bus.if_ready) begin
          w_if_valid_nxt = 1'b0;
          w_state_nxt    = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_REQ;
      r_fetch_pc <= RESET_PC_W;
      r_req_pc   <= RESET_PC_W;
      r_discard  <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_pc    <= 32'h0;
      r_if_inst  <= 32'h0;
      r_live     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_pc   <= w_req_pc_nxt;
      r_discard  <= w_discard_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_inst  <= w_if_inst_nxt;
      r_live     <= 1'b1;
    end
  end

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_fetch_pc;
  assign bus.if_valid  = r_if_valid;
  assign bus.if_pc     = r_if_pc;
  assign bus.if_inst   = r_if_inst;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. Reference model: the
// architectural stream of accepted PCs, i.e. the next accepted instruction is
// the previous one + 4 unless a redirect intervened, in which case it is the
// aligned target. Memory returns addr ^ 32'hA5A5_0000. A second instance with
// RESET_PC = 32'hFFFF_FFFC covers PC wrap-around.
module tb_fetch_unit;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();
  fetch_unit_if wbus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(wbus));

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  int w_acc = 0;
  int gnt_pct = 100;
  int fixed_lat = 1;
  bit pending = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] w_exp = 32'hFFFF_FFFC;
  bit w_wrap_seen = 1'b0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Redirect pulse; caller is just after a rising edge.
  task automatic do_redirect(input logic [31:0] t);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = t;
    exp_q.delete();
    exp_q.push_back(t & 32'hFFFF_FFFC);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    bit f;
    f = bus.imem_req;
    for (int i = 0; i < 100 && !f; i++) begin
      @(posedge clk); #1;
      f = bus.imem_req;
    end
    chk(f, nm, 32'(bus.imem_req), 32'h1);
  endtask

  task automatic wait_acc(input int n, input string nm);
    int tgt;
    tgt = n_acc + n;
    for (int i = 0; i < 400 && n_acc < tgt; i++) @(posedge clk);
    #1;
    chk(n_acc >= tgt, nm, 32'(n_acc), 32'(tgt));
  endtask

  // Memory model for the main DUT: one outstanding request, gnt decided
  // at the falling edge for the next rising edge.
  initial begin
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      bus.imem_gnt = 1'b0;
      bus.imem_rvalid = 1'b0;
      if (!rst_n) pending = 1'b0;
      else if (pending) begin
        cnt--;
        if (cnt <= 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = pend_addr ^ K;
          pending = 1'b0;
        end
      end else if (bus.imem_req && int'($urandom_range(99)) < gnt_pct) begin
        bus.imem_gnt = 1'b1;
        pending   = 1'b1;
        pend_addr = bus.imem_addr;
        cnt = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(3, 1));
        chk(bus.imem_addr[1:0] == 2'b00, "addr_align", bus.imem_addr, bus.imem_addr & 32'hFFFF_FFFC);
      end
    end
  end

  // Scoreboard monitor for the main DUT.
  initial begin
    bit hold;
    logic [31:0] hpc, hinst, e;
    hold = 1'b0; hpc = 32'h0; hinst = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) hold = 1'b0;
      else begin
        if (hold) begin
          chk(bus.if_valid, "hold_valid", 32'(bus.if_valid), 32'h1);
          chk(bus.if_pc == hpc, "hold_pc", bus.if_pc, hpc);
          chk(bus.if_inst == hinst, "hold_inst", bus.if_inst, hinst);
        end
        if (bus.if_valid) chk(!bus.imem_req, "no_prefetch", 32'(bus.imem_req), 32'h0);
        if (bus.if_valid && bus.if_ready && !bus.redirect_valid) begin
          if (exp_q.size() == 0) chk(1'b0, "sb_empty", bus.if_pc, 32'h0);
          else begin
            e = exp_q.pop_front();
            chk(bus.if_pc == e, "if_pc", bus.if_pc, e);
            chk(bus.if_inst == (e ^ K), "if_inst", bus.if_inst, e ^ K);
            exp_q.push_back(e + 32'd4);
          end
          n_acc++;
        end
        hold  = bus.if_valid && !bus.if_ready && !bus.redirect_valid;
        hpc   = bus.if_pc;
        hinst = bus.if_inst;
      end
    end
  end

  // Memory, decode and checker for the wrap-around instance.
  initial begin
    bit wpend;
    logic [31:0] waddr;
    wpend = 1'b0; waddr = 32'h0;
    wbus.redirect_valid = 1'b0; wbus.redirect_target = 32'h0; wbus.if_ready = 1'b1;
    wbus.imem_gnt = 1'b0; wbus.imem_rvalid = 1'b0; wbus.imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      wbus.imem_gnt = 1'b0;
      wbus.imem_rvalid = 1'b0;
      if (!rst_n) wpend = 1'b0;
      else begin
        if (wbus.if_valid) begin
          chk(wbus.if_pc == w_exp, "wrap_pc", wbus.if_pc, w_exp);
          chk(wbus.if_inst == (w_exp ^ K), "wrap_inst", wbus.if_inst, w_exp ^ K);
          if (w_exp == 32'h0) w_wrap_seen = 1'b1;
          w_exp = w_exp + 32'd4;
          w_acc++;
        end
        if (wpend) begin
          wbus.imem_rvalid = 1'b1;
          wbus.imem_rdata  = waddr ^ K;
          wpend = 1'b0;
        end else if (wbus.imem_req) begin
          wbus.imem_gnt = 1'b1;
          wpend = 1'b1;
          waddr = wbus.imem_addr;
        end
      end
    end
  end

  initial begin
    bit found;
    int a0;
    logic [31:0] t;
    bus.redirect_valid = 1'b0; bus.redirect_target = 32'h0; bus.if_ready = 1'b1;
    exp_q.push_back(32'h0);

    // Reset values, then first request one clock after release.
    #22;
    chk(!bus.if_valid, "rst_valid", 32'(bus.if_valid), 32'h0);
    chk(bus.if_pc == 32'h0, "rst_pc", bus.if_pc, 32'h0);
    chk(bus.if_inst == 32'h0, "rst_inst", bus.if_inst, 32'h0);
    chk(!bus.imem_req, "rst_req", 32'(bus.imem_req), 32'h0);
    #5 rst_n = 1'b1;
    @(negedge clk);
    chk(!bus.imem_req, "req_before_clk", 32'(bus.imem_req), 32'h0);
    @(negedge clk);
    chk(bus.imem_req, "req_after_clk", 32'(bus.imem_req), 32'h1);

    // Decode backpressure at pc 8.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      found = bus.if_valid && bus.if_pc == 32'h8;
    end
    chk(found, "wait_pc8", bus.if_pc, 32'h8);
    bus.if_ready = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk(bus.if_valid, "bp_valid", 32'(bus.if_valid), 32'h1);
    chk(bus.if_pc == 32'h8, "bp_pc", bus.if_pc, 32'h8);
    chk(!bus.imem_req, "bp_noreq", 32'(bus.imem_req), 32'h0);
    bus.if_ready = 1'b1;
    wait_req("bp_req");
    chk(bus.imem_addr == 32'hC, "bp_next_addr", bus.imem_addr, 32'hC);
    wait_acc(1, "seq_acc");

    // Redirect while waiting on a 3-cycle memory for address 4.
    fixed_lat = 3;
    do_redirect(32'h4);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      found = pending && pend_addr == 32'h4;
    end
    chk(found, "wait_gnt4", pend_addr, 32'h4);
    do_redirect(32'h100);
    wait_req("wait_redir_req");
    chk(bus.imem_addr == 32'h100, "wait_redir_addr", bus.imem_addr, 32'h100);
    wait_acc(1, "wait_redir_acc");

    // Redirect in S_OUT together with if_ready.
    bus.if_ready = 1'b0;
    do_redirect(32'h10);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      found = bus.if_valid && bus.if_pc == 32'h10;
    end
    chk(found, "wait_pc10", bus.if_pc, 32'h10);
    bus.if_ready = 1'b1;
    do_redirect(32'h40);
    chk(!bus.if_valid, "out_redir_drop", 32'(bus.if_valid), 32'h0);
    wait_req("out_redir_req");
    chk(bus.imem_addr == 32'h40, "out_redir_addr", bus.imem_addr, 32'h40);
    wait_acc(1, "out_redir_acc");

    // Grant stall with a misaligned redirect in the middle.
    fixed_lat = 1;
    gnt_pct = 0;
    wait_req("stall_req");
    @(posedge clk); #1;
    do_redirect(32'h203);
    chk(bus.imem_req && bus.imem_addr == 32'h200, "stall_addr", bus.imem_addr, 32'h200);
    @(posedge clk); #1;
    gnt_pct = 100;
    wait_acc(1, "stall_acc");

    // Randomized traffic.
    gnt_pct = 70;
    fixed_lat = 0;
    a0 = n_acc;
    for (int c = 0; c < 1500; c++) begin
      bus.if_ready = ($urandom_range(3) != 0);
      if ($urandom_range(9) == 0) begin
        t = $urandom;
        if ($urandom_range(7) == 0) t = 32'hFFFF_FFF4 | (t & 32'h3);
        else t = t & 32'h0000_3FFF;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = t;
        exp_q.delete();
        exp_q.push_back(t & 32'hFFFF_FFFC);
      end else begin
        bus.redirect_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.redirect_valid = 1'b0;
    bus.if_ready = 1'b1;
    gnt_pct = 100;
    wait_acc(3, "rand_drain");
    chk(n_acc - a0 > 20, "rand_progress", 32'(n_acc - a0), 32'd21);

    // Asynchronous reset in the middle of S_WAIT.
    fixed_lat = 3;
    found = pending;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      found = pending;
    end
    chk(found, "wait_pending", 32'(pending), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk(!bus.imem_req, "arst_req", 32'(bus.imem_req), 32'h0);
    chk(!bus.if_valid, "arst_valid", 32'(bus.if_valid), 32'h0);
    chk(bus.if_pc == 32'h0, "arst_pc", bus.if_pc, 32'h0);
    chk(bus.if_inst == 32'h0, "arst_inst", bus.if_inst, 32'h0);
    exp_q.delete();
    exp_q.push_back(32'h0);
    w_exp = 32'hFFFF_FFFC;
    #13 rst_n = 1'b1;
    wait_acc(2, "post_reset_acc");

    chk(w_wrap_seen, "wrap_seen", 32'(w_wrap_seen), 32'h1);
    chk(w_acc >= 2, "wrap_acc", 32'(w_acc), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
